stream_mux_rr: RTL and testbench

- Parametrised N-to-1 stream multiplexer. Successor to the combinational 4-bit 2:1/4:1 muxes.
- Each input channel carries W-bit data with a valid/ready handshake.
- Channel selection is either round-robin arbitration or a forced external select.
- Output is a single registered stage with valid/ready. Used to merge several producer streams onto one consumer.

---
 rtl/stream_mux_rr.sv | 101 ++++++++++
 tb/tb_stream_mux_rr.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-to-1 valid/ready stream mux with round-robin or forced-select arbitration
//
// Merges N producer streams onto one consumer through a single registered
// output stage. The channel is picked by round-robin arbitration (mode=0) or
// by the external select (mode=1).
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   in_data    N*W channel data, channel i at [i*W +: W]
//   in_valid   per-channel data-available flags
//   in_ready   per-channel accept strobes (combinational, at most one high)
//   mode       0 = round-robin, 1 = forced select
//   sel        channel index used when mode = 1
//   out_data   registered output word
//   out_chan   index of the channel that produced out_data
//   out_valid  output register holds a word
//   out_ready  consumer accepts out_data this cycle
module stream_mux_rr #(
  parameter int W    = 4,
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_chan,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [W-1:0]    chan_data [N];
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] grant;
  logic            grant_vld;
  logic            load_en;
  logic            xfer;

  for (genvar i = 0; i < N; i++) begin : g_split
    assign chan_data[i] = in_data[i*W +: W];
  end

  // The output register can accept a word when empty or drained this cycle.
  assign load_en = !out_valid || out_ready;

  // Grant selection. Round-robin scans ptr+1, ptr+2, ... modulo N so the
  // channel granted last has the lowest priority next time.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    if (mode) begin
      // sel may exceed N-1 when N is not a power of two; that is no grant.
      if (int'(sel) < N && in_valid[sel]) begin
        grant_vld = 1'b1;
        grant     = sel;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!grant_vld && in_valid[SELW'(idx)]) begin
          grant_vld = 1'b1;
          grant     = SELW'(idx);
        end
      end
    end
  end

  // A grant implies in_valid of that channel, so a grant with load_en is a transfer.
  assign xfer = load_en && grant_vld;

  always_comb begin
    in_ready = '0;
    if (!rst && xfer) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SELW'(N - 1);
    end else if (xfer) begin
      // Only the granted channel's data is routed, so X elsewhere cannot leak.
      out_data  <= chan_data[grant];
      out_chan  <= grant;
      out_valid <= 1'b1;
      ptr       <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - randomized and directed bench for stream_mux_rr against a behavioural model
module tb_stream_mux_rr;
  localparam int W    = 4;
  localparam int N    = 4;
  localparam int SELW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*W-1:0]  in_data = '0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_ready;
  logic            mode = 1'b0;
  logic [SELW-1:0] sel = '0;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_chan;
  logic            out_valid;
  logic            out_ready = 1'b0;

  logic [3*W-1:0]  in_data3 = '0;
  logic [2:0]      in_valid3 = '0;
  logic [2:0]      in_ready3;
  logic            mode3 = 1'b0;
  logic [1:0]      sel3 = '0;
  logic [W-1:0]    out_data3;
  logic [1:0]      out_chan3;
  logic            out_valid3;
  logic            out_ready3 = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  stream_mux_rr #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_mux_rr #(.W(W), .N(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode3), .sel(sel3), .out_data(out_data3), .out_chan(out_chan3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the next granted channel is the valid one at the
  // smallest circular distance after the last granted channel.
  logic            m_valid;
  logic [W-1:0]    m_data;
  logic [SELW-1:0] m_chan;
  int              m_ptr;

  function automatic int model_grant();
    int best  = -1;
    int bestd = N;
    int d;
    if (mode) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
    for (int i = 0; i < N; i++) begin
      if (in_valid[i[SELW-1:0]]) begin
        d = (i - m_ptr - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (!rst && !(m_valid && !out_ready) && g >= 0) r[g[SELW-1:0]] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin : model_update
    int g;
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= '0;
      m_ptr   <= N - 1;
    end else begin
      g = model_grant();
      if ((!m_valid || out_ready) && g >= 0) begin
        m_valid <= 1'b1;
        m_data  <= W'(in_data >> (g * W));
        m_chan  <= g[SELW-1:0];
        m_ptr   <= g;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_data", 32'(out_data), 32'(m_data));
      check("out_chan", 32'(out_chan), 32'(m_chan));
      check("in_ready", 32'(in_ready), 32'(model_ready()));
    end
  end

  task automatic rst_on();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("in_ready_in_rst", 32'(in_ready), 32'h0);
  endtask

  task automatic rst_off();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_a [5];
    exp_a[0] = 4'ha; exp_a[1] = 4'hb; exp_a[2] = 4'hc; exp_a[3] = 4'hd; exp_a[4] = 4'ha;

    // Round-robin, all valid
    repeat (2) @(posedge clk);
    #1;
    mode = 1'b0; in_valid = 4'hf; in_data = {4'hd, 4'hc, 4'hb, 4'ha}; out_ready = 1'b1;
    check("in_ready_in_rst", 32'(in_ready), 32'h0);
    chk_en = 1'b1;
    rst_off();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_chan", 32'(out_chan), 32'h0);
    check("first_grant_ch0", 32'(in_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("rr_chan", 32'(out_chan), 32'(k % 4));
      check("rr_data", 32'(out_data), 32'(exp_a[k]));
      check("rr_valid", 32'(out_valid), 32'h1);
    end

    // Sparse requests on channels 1 and 3
    rst_on();
    in_valid = 4'b1010; in_data = {4'h3, 4'h0, 4'h7, 4'h0};
    rst_off();
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("sparse_chan", 32'(out_chan), (k % 2 == 0) ? 32'h1 : 32'h3);
      check("sparse_data", 32'(out_data), (k % 2 == 0) ? 32'h7 : 32'h3);
      check("sparse_ready02", 32'(in_ready & 4'b0101), 32'h0);
    end

    // Backpressure after 'hb is loaded
    rst_on();
    in_valid = 4'hf; in_data = {4'hd, 4'hc, 4'hb, 4'ha};
    rst_off();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bp_loaded_b", 32'(out_data), 32'hb);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold_data", 32'(out_data), 32'hb);
      check("bp_hold_valid", 32'(out_valid), 32'h1);
      check("bp_ready_low", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'h4);
    cyc();
    check("bp_next_c", 32'(out_data), 32'hc);
    check("bp_no_bubble", 32'(out_valid), 32'h1);

    // Forced select of channel 2
    @(posedge clk); #1;
    mode = 1'b1; sel = 2'd2;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("force_data", 32'(out_data), 32'hc);
      check("force_chan", 32'(out_chan), 32'h2);
      check("force_ready", 32'(in_ready), 32'h4);
    end
    @(posedge clk); #1;
    in_valid = 4'b1011;
    @(negedge clk);
    check("force_noreq_ready", 32'(in_ready), 32'h0);
    cyc();
    check("force_drain_valid", 32'(out_valid), 32'h0);
    check("force_drain_hold", 32'(out_data), 32'hc);

    // X isolation on a non-granted channel
    @(posedge clk); #1;
    in_valid = 4'hf; sel = 2'd0;
    in_data[3*W +: W] = 'x;
    in_data[0 +: W] = 4'h7;
    repeat (2) begin
      cyc();
      check("xiso_data", 32'(out_data), 32'h7);
    end

    // Reset while a word is held under backpressure
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_data", 32'(out_data), 32'h0);
    check("async_rst_ready", 32'(in_ready), 32'h0);
    mode = 1'b0; in_valid = 4'hf; in_data = {4'hd, 4'hc, 4'hb, 4'ha}; out_ready = 1'b1;
    rst_off();
    cyc();
    check("post_rst_chan", 32'(out_chan), 32'h0);
    check("post_rst_data", 32'(out_data), 32'ha);

    // Three-channel instance: out-of-range select and pointer wrap
    rst_on();
    in_data3 = {4'h5, 4'h2, 4'h1}; in_valid3 = 3'b111; mode3 = 1'b1; sel3 = 2'd3;
    rst_off();
    @(negedge clk);
    check("n3_sel3_ready", 32'(in_ready3), 32'h0);
    cyc();
    check("n3_sel3_valid", 32'(out_valid3), 32'h0);
    @(posedge clk); #1;
    sel3 = 2'd2;
    #1;
    check("n3_sel2_ready", 32'(in_ready3), 32'h4);
    cyc();
    check("n3_sel2_data", 32'(out_data3), 32'h5);
    check("n3_sel2_chan", 32'(out_chan3), 32'h2);
    @(posedge clk); #1;
    mode3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("n3_wrap_chan", 32'(out_chan3), 32'(k));
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = N'($urandom());
      in_data   = (N*W)'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      mode      = ($urandom_range(0, 4) == 0);
      sel       = SELW'($urandom());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
